tree_reduce_ctrl: RTL
=====================

TREE_REDUCE_CTRL -- requirements
Module: tree_reduce_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element, tree-sum and accumulator width in bits.
REQ-002 SHALL have parameter LEN_W, default 16, width of the chunk-count field.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_valid  input  1  job request.
REQ-006 SHALL have port cfg_ready  output  1  job accepted when cfg_valid && cfg_ready.
REQ-007 SHALL have port cfg_len  input  LEN_W  number of 16-element chunks in the job.
REQ-008 SHALL have port in_valid  input  1  chunk available.
REQ-009 SHALL have port in_ready  output  1  chunk consumed when in_valid && in_ready.
REQ-010 SHALL have port in_data  input  16 x WIDTH (unpacked [15:0])  chunk elements.
REQ-011 SHALL have port tree_in  output  16 x WIDTH (unpacked [15:0])  operands driven to the external 16-input adder tree.
REQ-012 SHALL have port tree_out  input  WIDTH  combinational sum returned by the tree.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  result taken when out_valid && out_ready.
REQ-015 SHALL have port out_data  output  WIDTH  accumulated job sum.
REQ-016 SHALL have port out_ovf  output  1  sticky overflow flag for the job.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-018 IDLE SHALL drive cfg_ready=1, in_ready=0 and out_valid=0.
REQ-019 IDLE, on cfg accept with cfg_len==0, SHALL go to DONE with acc=0 and ovf=0.
REQ-020 IDLE, on cfg accept with cfg_len!=0, SHALL load cnt=cfg_len, clear acc and ovf, and go to RUN.
REQ-021 RUN SHALL drive in_ready=1, cfg_ready=0 and tree_in=in_data.
REQ-022 In every state other than RUN, tree_in SHALL be all zero.
REQ-023 In RUN, on each chunk accept, acc SHALL become acc+tree_out and cnt SHALL decrement by 1.
REQ-024 In RUN, when a chunk is accepted with cnt==1, the FSM SHALL go to DONE; out_valid SHALL assert the next cycle, giving a latency of 1 cycle after the last beat.
REQ-025 In RUN with in_valid low, acc, cnt and state SHALL hold; gaps between chunks are unbounded.
REQ-026 DONE SHALL drive out_valid=1, out_data=acc and out_ovf=ovf, and SHALL keep them stable until out_ready; cfg_ready=0 and in_ready=0.
REQ-027 DONE, on out_ready, SHALL go to IDLE; a new cfg SHALL NOT be accepted in that same cycle, so there is at least 1 IDLE cycle between jobs.
REQ-028 Outside DONE, out_data SHALL equal the current acc value and out_ovf the current ovf value.
REQ-029 Addition SHALL be modulo 2^WIDTH unless REDUCE_SAT_EN is defined.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, acc=0, cnt=0 and ovf=0.
REQ-031 While in reset, outputs SHALL be cfg_ready=1, in_ready=0, out_valid=0, out_data=0, out_ovf=0 and tree_in all zero.
REQ-032 A reset during RUN or DONE SHALL abandon the job with no result produced.

Configuration
REQ-033 The macro REDUCE_SAT_EN SHALL control the accumulation mode.
REQ-034 With REDUCE_SAT_EN defined, acc and tree_out SHALL be treated as signed two's complement, and acc SHALL saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-035 With REDUCE_SAT_EN defined, any saturating beat SHALL set ovf, and ovf SHALL stay set until the next job is accepted.
REQ-036 Without REDUCE_SAT_EN, addition SHALL wrap and out_ovf SHALL be constant 0.

Structure
REQ-037 A shared package reduce_pkg SHALL hold the LANES=16 constant and the state enum typedef (IDLE, RUN, DONE).
REQ-038 The adder tree SHALL remain outside the block; the block contains no sub-module and places only the FSM, the counter and the accumulator adder/saturator inline.

Verification
REQ-039 cfg_len=2; chunk1 all 1, chunk2 all 2 -> out_data=48, out_valid 1 cycle after 2nd beat, out_ovf=0.
REQ-040 cfg_len=0 -> out_valid the next cycle with out_data=0; in_ready never asserts.
REQ-041 cfg_len=3; in_valid gaps of 2 cycles; out_ready low 5 cycles -> out_data stable throughout, cfg_ready=0 until out_ready, then 1 cycle later cfg_ready=1.
REQ-042 cfg_len=3; tree_out=0x7000 each beat -> out_data=0x5000, out_ovf=0 without macro; out_data=0x7FFF, out_ovf=1 with REDUCE_SAT_EN.
REQ-043 cfg_len=4; rst_n low 1 cycle after 1st beat -> all outputs at reset values; next job with cfg_len=1 and chunk all 3 -> out_data=48.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared constants and state encoding for the tree-reduction controller.
package reduce_pkg;

    localparam int LANES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tree_reduce_ctrl.sv
// Streams 16-element chunks through an external adder tree and accumulates the job sum.
// Define REDUCE_SAT_EN for signed saturating accumulation with a sticky overflow flag.
module tree_reduce_ctrl
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [LANES-1:0],
    output logic [WIDTH-1:0] tree_in [LANES-1:0],
    input  logic [WIDTH-1:0] tree_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic [WIDTH-1:0] acc_nxt;
    logic             ovf_nxt;

`ifdef REDUCE_SAT_EN
    logic [WIDTH:0] sum_ext;

    // Sign-extended add; differing top two bits means the signed result left range.
    always_comb begin
        sum_ext = {acc[WIDTH-1], acc} + {tree_out[WIDTH-1], tree_out};
        acc_nxt = sum_ext[WIDTH-1:0];
        ovf_nxt = 1'b0;
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            ovf_nxt = 1'b1;
            acc_nxt = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_nxt = acc + tree_out;
        ovf_nxt = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= cfg_len;
                        state <= (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        acc <= acc_nxt;
                        ovf <= ovf | ovf_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    // Return to IDLE only; the next job is taken from IDLE a cycle later.
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshakes decode the registered state; reset forces the idle-facing values.
    assign cfg_ready = !rst_n || (state == IDLE);
    assign in_ready  = rst_n && (state == RUN);
    assign out_valid = rst_n && (state == DONE);
    assign out_data  = rst_n ? acc : '0;
    assign out_ovf   = rst_n && ovf;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            tree_in[i] = (rst_n && state == RUN) ? in_data[i] : '0;
        end
    end

endmodule
